// File: rtl/fpu_divsqrt_if.sv
// fpu_divsqrt_if: fc request and fdiv/fsqrt sequencer status bundle; cancel exists only with DIVSQRT_CANCEL_EN.
interface fpu_divsqrt_if #(parameter int CW = 5);
  logic [2:0] fc;
`ifdef DIVSQRT_CANCEL_EN
  logic cancel;
`endif
  logic stall_div_sqrt;
  logic busy;
  logic load;
  logic iter_en;
  logic is_sqrt;
  logic [CW-1:0] count;
  logic done;
  modport master(
`ifdef DIVSQRT_CANCEL_EN
    output cancel,
`endif
    output fc,
    input stall_div_sqrt, busy, load, iter_en, is_sqrt, count, done
  );
  modport slave(
`ifdef DIVSQRT_CANCEL_EN
    input cancel,
`endif
    input fc,
    output stall_div_sqrt, busy, load, iter_en, is_sqrt, count, done
  );
endinterface

// File: rtl/fpu_divsqrt_seq.sv
// fpu_divsqrt_seq: sequencer for the shared iterative fdiv/fsqrt unit (stall, load, iterate, done).
// Optional abort input enabled by defining DIVSQRT_CANCEL_EN.
module fpu_divsqrt_seq #(
  parameter int DIV_ITER  = 14,
  parameter int SQRT_ITER = 12,
  parameter int CW        = 5
) (
  input logic clk,
  input logic rst,
  fpu_divsqrt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_ITER - 1);
  localparam logic [CW-1:0] SQRT_N = CW'(SQRT_ITER - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_count;
  logic r_is_sqrt;
  logic w_cancel, w_stall, w_load, w_iter_en, w_done;
`ifdef DIVSQRT_CANCEL_EN
  assign w_cancel = bus.cancel & (r_state == LOAD || r_state == ITER);
`else
  assign w_cancel = 1'b0;
`endif
  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_load    = 1'b0;
    w_iter_en = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = bus.fc[2] & ~rst;
        w_next  = bus.fc[2] ? LOAD : IDLE;
      end
      LOAD: begin
        w_stall = ~w_cancel;
        w_load  = ~w_cancel;
        w_next  = w_cancel ? IDLE : ITER;
      end
      ITER: begin
        w_stall   = ~w_cancel;
        w_iter_en = ~w_cancel;
        w_next    = w_cancel ? IDLE : (r_count == '0 ? DONE : ITER);
      end
      default: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_is_sqrt <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD && !w_cancel) begin
        r_is_sqrt <= bus.fc[1];
        r_count   <= bus.fc[1] ? SQRT_N : DIV_N;
      end else if (r_state == ITER && r_count != '0) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
  assign bus.stall_div_sqrt = w_stall;
  assign bus.load           = w_load;
  assign bus.iter_en        = w_iter_en;
  assign bus.done           = w_done;
  assign bus.busy           = (r_state == LOAD || r_state == ITER);
  assign bus.is_sqrt        = r_is_sqrt;
  assign bus.count          = r_count;
endmodule

// File: tb/tb_fpu_divsqrt_seq.sv
// tb_fpu_divsqrt_seq: directed and random checks of the fdiv/fsqrt sequencer against a latency-level model.
module tb_fpu_divsqrt_seq;
  localparam int DIV_ITER = 14, SQRT_ITER = 12, CW = 5;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fpu_divsqrt_if #(.CW(CW)) bus();
  fpu_divsqrt_seq #(.DIV_ITER(DIV_ITER), .SQRT_ITER(SQRT_ITER), .CW(CW)) dut(.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0, cyc = 0;
  bit m_act = 0, m_sqrt = 0, e_sqrt = 0, cnt_known = 1;
  int m_start = 0, m_n = 0, e_count = 0;
  logic [2:0] last_f = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input bit s, input bit b, input bit l, input bit it, input bit d);
    chk("stall", 32'(bus.stall_div_sqrt), 32'(s));
    chk("busy", 32'(bus.busy), 32'(b));
    chk("load", 32'(bus.load), 32'(l));
    chk("iter_en", 32'(bus.iter_en), 32'(it));
    chk("done", 32'(bus.done), 32'(d));
    chk("is_sqrt", 32'(bus.is_sqrt), 32'(e_sqrt));
    if (cnt_known) chk("count", 32'(bus.count), 32'(e_count));
  endtask

  // One clock cycle with fc/cancel applied; expectations come from the op's start cycle and length.
  task automatic tick(input logic [2:0] f, input bit c);
    int rel;
    bit canc, es, eb, el, ei, ed;
    @(negedge clk);
    rst = 1'b0;
    bus.fc = f;
`ifdef DIVSQRT_CANCEL_EN
    bus.cancel = c;
`endif
    last_f = f;
    #1;
    {canc, es, eb, el, ei, ed} = '0;
    if (!m_act && f[2]) begin
      m_act = 1; m_start = cyc; m_sqrt = f[1]; m_n = f[1] ? SQRT_ITER : DIV_ITER;
    end
    if (m_act) begin
      rel = cyc - m_start;
`ifdef DIVSQRT_CANCEL_EN
      canc = c && rel >= 1 && rel <= m_n + 1;
`endif
      eb = rel >= 1 && rel <= m_n + 1;
      el = rel == 1 && !canc;
      ei = rel >= 2 && rel <= m_n + 1 && !canc;
      es = rel <= m_n + 1 && !canc;
      ed = rel == m_n + 2;
      if (rel >= 2) begin
        e_sqrt = m_sqrt;
        cnt_known = 1;
        e_count = rel <= m_n + 1 ? m_n + 1 - rel : 0;
      end
      if (canc) cnt_known = 0;
      if (canc || rel == m_n + 2) m_act = 0;
    end
    check_all(es, eb, el, ei, ed);
    cyc++;
  endtask

  task automatic reset_cyc(input logic [2:0] f);
    @(negedge clk);
    rst = 1'b1;
    bus.fc = f;
    #1;
    m_act = 0; e_sqrt = 0; e_count = 0; cnt_known = 1;
    check_all(0, 0, 0, 0, 0);
    cyc++;
  endtask

  initial begin
    bus.fc = 3'b100;
`ifdef DIVSQRT_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    repeat (3) reset_cyc(3'b100);
    repeat (3) tick(3'b000, 0);
    repeat (17) tick(3'b100, 0);
    repeat (3) tick(3'b000, 0);
    repeat (15) tick(3'b110, 0);
    repeat (3) tick(3'b000, 0);
    repeat (19) tick(3'b100, 0);
    repeat (20) tick(3'b000, 0);
    repeat (5) tick(3'b010, 0);
    tick(3'b011, 0);
    tick(3'b001, 0);
    repeat (8) tick(3'b100, 0);
    reset_cyc(3'b100);
    repeat (3) tick(3'b000, 0);
`ifdef DIVSQRT_CANCEL_EN
    repeat (5) tick(3'b100, 0);
    tick(3'b100, 1);
    repeat (3) tick(3'b000, 0);
    repeat (15) tick(3'b100, 0);
    tick(3'b100, 1);
    repeat (3) tick(3'b000, 0);
    tick(3'b111, 1);
    repeat (16) tick(3'b111, 0);
    repeat (2) tick(3'b000, 0);
`endif
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) reset_cyc(3'($urandom_range(0, 7)));
      else tick((m_act && cyc - m_start < 2) ? last_f : 3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
